// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray-code counter with load, wrap/saturate mode,
// sticky overflow/underflow flags and a one-cycle rollover pulse.
module gray_counter_n #(
   parameter int unsigned WIDTH    = 3,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             En,
   input  logic             Up,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadVal,
   input  logic             ClrFlags,
   output logic [WIDTH-1:0] Output,
   output logic [WIDTH-1:0] BinOut,
   output logic             Overflow,
   output logic             Underflow,
   output logic             Wrap
);

   if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("gray_counter_n: WIDTH must be in 2..16");
   end

   localparam logic [WIDTH-1:0] MAX  = '1;
   localparam logic [WIDTH-1:0] ZERO = '0;

   logic [WIDTH-1:0] bin_nxt;
   logic [WIDTH-1:0] gray_nxt;
   logic             ov_set;
   logic             uf_set;
   logic             ov_nxt;
   logic             uf_nxt;
   logic             wrap_nxt;

   // Next count: load beats enable, terminal counts either roll or hold.
   always_comb begin
      bin_nxt  = BinOut;
      ov_set   = 1'b0;
      uf_set   = 1'b0;
      wrap_nxt = 1'b0;
      if (Load) begin
         bin_nxt = LoadVal;
      end else if (En) begin
         if (Up) begin
            if (BinOut == MAX) begin
               ov_set = 1'b1;
               if (!SATURATE) begin
                  bin_nxt  = ZERO;
                  wrap_nxt = 1'b1;
               end
            end else begin
               bin_nxt = BinOut + WIDTH'(1);
            end
         end else begin
            if (BinOut == ZERO) begin
               uf_set = 1'b1;
               if (!SATURATE) begin
                  bin_nxt  = MAX;
                  wrap_nxt = 1'b1;
               end
            end else begin
               bin_nxt = BinOut - WIDTH'(1);
            end
         end
      end
   end

   // Gray is derived from the next binary so both register on the same edge.
   always_comb begin
      gray_nxt = bin_nxt ^ (bin_nxt >> 1);
      ov_nxt   = ov_set | (Overflow  & ~ClrFlags);
      uf_nxt   = uf_set | (Underflow & ~ClrFlags);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         BinOut    <= '0;
         Output    <= '0;
         Overflow  <= 1'b0;
         Underflow <= 1'b0;
         Wrap      <= 1'b0;
      end else begin
         BinOut    <= bin_nxt;
         Output    <= gray_nxt;
         Overflow  <= ov_nxt;
         Underflow <= uf_nxt;
         Wrap      <= wrap_nxt;
      end
   end

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed bench for gray_counter_n: wrap and saturate at WIDTH=3, wrap at
// WIDTH=2, all driven from one shared stimulus stream.
module tb_gray_counter_n;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       up;
   logic       load;
   logic [2:0] ldval;
   logic       clr;

   logic [2:0] o0, b0;
   logic       ov0, uf0, w0;
   logic [2:0] o1, b1;
   logic       ov1, uf1, w1;
   logic [1:0] o2, b2;
   logic       ov2, uf2, w2;

   int checks = 0;
   int errors = 0;

   logic [2:0] gtab [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
   logic [2:0] prev;

   gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) u_wrap3 (
      .Clk(clk), .Reset_n(rst_n), .En(en), .Up(up), .Load(load),
      .LoadVal(ldval), .ClrFlags(clr), .Output(o0), .BinOut(b0),
      .Overflow(ov0), .Underflow(uf0), .Wrap(w0));

   gray_counter_n #(.WIDTH(3), .SATURATE(1'b1)) u_sat3 (
      .Clk(clk), .Reset_n(rst_n), .En(en), .Up(up), .Load(load),
      .LoadVal(ldval), .ClrFlags(clr), .Output(o1), .BinOut(b1),
      .Overflow(ov1), .Underflow(uf1), .Wrap(w1));

   gray_counter_n #(.WIDTH(2), .SATURATE(1'b0)) u_wrap2 (
      .Clk(clk), .Reset_n(rst_n), .En(en), .Up(up), .Load(load),
      .LoadVal(ldval[1:0]), .ClrFlags(clr), .Output(o2), .BinOut(b2),
      .Overflow(ov2), .Underflow(uf2), .Wrap(w2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected Gray comes from the hand-written table, indexed by expected binary.
   task automatic chk_state(input string tag, input logic [2:0] a_bin, input logic [2:0] a_gray,
                            input logic a_w, input logic a_o, input logic a_u,
                            input logic [2:0] e_bin, input logic e_w, input logic e_o,
                            input logic e_u);
      chk({tag, ".bin"},  32'(a_bin),  32'(e_bin));
      chk({tag, ".gray"}, 32'(a_gray), 32'(gtab[e_bin]));
      chk({tag, ".wrap"}, 32'(a_w), 32'(e_w));
      chk({tag, ".ov"},   32'(a_o), 32'(e_o));
      chk({tag, ".uf"},   32'(a_u), 32'(e_u));
   endtask

   task automatic s0(input string t, input logic [2:0] b, input logic w, input logic o, input logic u);
      chk_state({"w3.", t}, b0, o0, w0, ov0, uf0, b, w, o, u);
   endtask
   task automatic s1(input string t, input logic [2:0] b, input logic w, input logic o, input logic u);
      chk_state({"s3.", t}, b1, o1, w1, ov1, uf1, b, w, o, u);
   endtask
   task automatic s2(input string t, input logic [2:0] b, input logic w, input logic o, input logic u);
      chk_state({"w2.", t}, {1'b0, b2}, {1'b0, o2}, w2, ov2, uf2, b, w, o, u);
   endtask

   // Drive inputs just after an edge, then sample 1 time unit after the next edge.
   task automatic step(input logic e, input logic u, input logic l, input logic [2:0] v,
                       input logic c);
      en = e; up = u; load = l; ldval = v; clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en = 1'b0; up = 1'b0; load = 1'b0; ldval = '0; clr = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      en = 1'b0; up = 1'b0; load = 1'b0; ldval = '0; clr = 1'b0;
      rst_n = 1'b0;
      #3;
      s0("rst", 3'd0, 1'b0, 1'b0, 1'b0);
      s1("rst", 3'd0, 1'b0, 1'b0, 1'b0);
      s2("rst", 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Count up nine times: WIDTH=3 wraps once, WIDTH=2 twice, saturate holds at 7.
      prev = 3'd0;
      for (int k = 1; k <= 9; k++) begin
         step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
         s0($sformatf("up%0d", k), 3'(k % 8), k == 8, k >= 8, 1'b0);
         s1($sformatf("up%0d", k), (k >= 7) ? 3'd7 : 3'(k), 1'b0, k >= 8, 1'b0);
         s2($sformatf("up%0d", k), 3'(k % 4), (k % 4) == 0, k >= 4, 1'b0);
         chk($sformatf("onebit%0d", k), 32'($countones(o0 ^ prev)), 32'd1);
         prev = o0;
      end
      step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
      s0("up10", 3'd2, 1'b0, 1'b1, 1'b0);
      s1("up10", 3'd7, 1'b0, 1'b1, 1'b0);
      s2("up10", 3'd2, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
      s0("dn_from2", 3'd1, 1'b0, 1'b1, 1'b0);
      s1("dn_from7", 3'd6, 1'b0, 1'b1, 1'b0);
      s2("dn_from2", 3'd1, 1'b0, 1'b1, 1'b0);

      // Underflow straight out of reset.
      do_reset();
      step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
      s0("uflow", 3'd7, 1'b1, 1'b0, 1'b1);
      s1("uflow", 3'd0, 1'b0, 1'b0, 1'b1);
      s2("uflow", 3'd3, 1'b1, 1'b0, 1'b1);

      // Load with En high takes no step; next edge counts from the loaded value.
      step(1'b1, 1'b1, 1'b1, 3'd5, 1'b0);
      s0("load5", 3'd5, 1'b0, 1'b0, 1'b1);
      s1("load5", 3'd5, 1'b0, 1'b0, 1'b1);
      s2("load1", 3'd1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
      s0("ld_up", 3'd6, 1'b0, 1'b0, 1'b1);
      s1("ld_up", 3'd6, 1'b0, 1'b0, 1'b1);
      s2("ld_up", 3'd2, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
      s0("roll", 3'd0, 1'b1, 1'b1, 1'b1);
      s1("sat", 3'd7, 1'b0, 1'b1, 1'b1);
      s2("roll", 3'd0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
      s0("load7", 3'd7, 1'b0, 1'b1, 1'b1);
      s2("load3", 3'd3, 1'b0, 1'b1, 1'b1);

      // Clear and set on the same edge: set wins; clear alone then drops both flags.
      step(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
      s0("clr_set", 3'd0, 1'b1, 1'b1, 1'b0);
      s1("clr_set", 3'd7, 1'b0, 1'b1, 1'b0);
      s2("clr_set", 3'd0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
      s0("clr_only", 3'd0, 1'b0, 1'b0, 1'b0);
      s1("clr_only", 3'd7, 1'b0, 1'b0, 1'b0);
      s2("clr_only", 3'd0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-cycle, with WIDTH=2 holding a pending Wrap.
      do_reset();
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
      s0("pre_rst", 3'd4, 1'b0, 1'b0, 1'b0);
      s2("pre_rst", 3'd0, 1'b1, 1'b1, 1'b0);
      en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      s0("async_rst", 3'd0, 1'b0, 1'b0, 1'b0);
      s2("async_rst", 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
      s0("restart1", 3'd1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
      s0("restart2", 3'd2, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
